// File: rtl/wb_dpbram_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_dpbram_pipe_if
// Description : Wishbone B4 pipelined bus bundle for one wb_dpbram_pipe port.
//               Signal directions are named from the slave's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_dpbram_pipe_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic            i_cyc;
    logic            i_stb;
    logic            i_we;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_data;
    logic [DW/8-1:0] i_sel;
    logic            o_stall;
    logic            o_ack;
    logic [DW-1:0]   o_data;

    modport master (
        output i_cyc, i_stb, i_we, i_addr, i_data, i_sel,
        input  o_stall, o_ack, o_data
    );

    modport slave (
        input  i_cyc, i_stb, i_we, i_addr, i_data, i_sel,
        output o_stall, o_ack, o_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_dpbram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_dpbram_pipe
// Description : True dual-port block RAM with two Wishbone B4 pipelined slave
//               ports. Byte selects, 1- or 2-cycle read latency, read-first
//               behaviour, port A wins byte collisions, optional post-reset
//               clear sequencer. DEPTH must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dpbram_pipe #(
    parameter int DW             = 32,
    parameter int DEPTH          = 1024,
    parameter int AW             = $clog2(DEPTH),
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic      i_clk,
    input  wire logic      i_reset,
    wb_dpbram_pipe_if.slave a,
    wb_dpbram_pipe_if.slave b
);

    localparam int c_NB = DW / 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam state_t        c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic          c_RST_STALL = (CLEAR_ON_RESET != 0);
    localparam logic [AW-1:0] c_LAST      = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_DEPTH_X   = (AW + 1)'(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_stall;

    logic          w_clr_we;
    logic          w_a_acc, w_b_acc;
    logic          w_a_inr, w_b_inr;
    logic          w_a_wr,  w_b_wr;
    logic          w_a_rd,  w_b_rd;
    logic [DW-1:0] w_a_rdata, w_b_rdata;

    logic          r_a_ack1, r_b_ack1;
    logic          w_a_ack_q, w_b_ack_q;
    logic [DW-1:0] w_a_dat_q, w_b_dat_q;

    // Clear sequencer: walk every word once after reset, then hold in IDLE
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= c_RST_STATE;
            r_clr_cnt <= '0;
            r_stall   <= c_RST_STALL;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                        r_stall <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign w_clr_we = (r_state == S_CLEAR);

    // Request qualification; out-of-range requests are acked but touch nothing
    assign w_a_acc = a.i_cyc & a.i_stb & ~r_stall;
    assign w_b_acc = b.i_cyc & b.i_stb & ~r_stall;
    assign w_a_inr = ({1'b0, a.i_addr} < c_DEPTH_X);
    assign w_b_inr = ({1'b0, b.i_addr} < c_DEPTH_X);
    assign w_a_wr  = w_a_acc &  a.i_we & w_a_inr;
    assign w_b_wr  = w_b_acc &  b.i_we & w_b_inr;
    assign w_a_rd  = w_a_acc & ~a.i_we & w_a_inr;
    assign w_b_rd  = w_b_acc & ~b.i_we & w_b_inr;

    // One RAM per byte lane so byte enables map onto plain write enables
    for (genvar k = 0; k < c_NB; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_a_q;
        logic [7:0] r_b_q;

        // B is written before A so A's byte lands last when both hit one word;
        // reads sample the pre-edge contents, giving read-first behaviour
        always_ff @(posedge i_clk) begin
            if (w_clr_we) begin
                r_mem[r_clr_cnt] <= 8'h00;
            end
            if (w_b_wr && b.i_sel[k]) begin
                r_mem[b.i_addr] <= b.i_data[8*k +: 8];
            end
            if (w_a_wr && a.i_sel[k]) begin
                r_mem[a.i_addr] <= a.i_data[8*k +: 8];
            end
            r_a_q <= w_a_rd ? r_mem[a.i_addr] : 8'h00;
            r_b_q <= w_b_rd ? r_mem[b.i_addr] : 8'h00;
        end

        assign w_a_rdata[8*k +: 8] = r_a_q;
        assign w_b_rdata[8*k +: 8] = r_b_q;
    end

    // First ack stage, aligned with the RAM read register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a_ack1 <= 1'b0;
            r_b_ack1 <= 1'b0;
        end else begin
            r_a_ack1 <= w_a_acc;
            r_b_ack1 <= w_b_acc;
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic          r_a_ack2, r_b_ack2;
        logic [DW-1:0] r_a_d2,   r_b_d2;

        // Output register stage; a dropped cyc kills acks still in flight
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_a_ack2 <= 1'b0;
                r_b_ack2 <= 1'b0;
                r_a_d2   <= '0;
                r_b_d2   <= '0;
            end else begin
                r_a_ack2 <= r_a_ack1 & a.i_cyc;
                r_b_ack2 <= r_b_ack1 & b.i_cyc;
                r_a_d2   <= r_a_ack1 ? w_a_rdata : '0;
                r_b_d2   <= r_b_ack1 ? w_b_rdata : '0;
            end
        end

        assign w_a_ack_q = r_a_ack2;
        assign w_b_ack_q = r_b_ack2;
        assign w_a_dat_q = r_a_d2;
        assign w_b_dat_q = r_b_d2;
    end else begin : g_lat1
        assign w_a_ack_q = r_a_ack1;
        assign w_b_ack_q = r_b_ack1;
        assign w_a_dat_q = w_a_rdata;
        assign w_b_dat_q = w_b_rdata;
    end

    // Gating by cyc suppresses any ack that would appear after the master quits
    assign a.o_stall = r_stall;
    assign b.o_stall = r_stall;
    assign a.o_ack   = w_a_ack_q & a.i_cyc;
    assign b.o_ack   = w_b_ack_q & b.i_cyc;
    assign a.o_data  = (w_a_ack_q & a.i_cyc) ? w_a_dat_q : '0;
    assign b.o_data  = (w_b_ack_q & b.i_cyc) ? w_b_dat_q : '0;

endmodule
`default_nettype wire
